net_packet_loader: RTL

- Synthesizable boot sequencer directly upstream of core_flattened's net_packet_flat_i.
- Streams a program image into the core: instructions, then register file, then PC, then barrier mask, then idles on NULL.
- Replaces the bench-side packet injection so FPGA builds boot the core from on-chip image ROMs.
- Image ROMs are external synchronous-read memories.

---
 rtl/net_packet_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/net_packet_loader.sv
// net_packet_loader: boot sequencer that streams a program image into the
// core as registered network packets: instructions, register file, PC,
// barrier mask, then NULL forever.
// Packet layout (55 bits): [54:45] ID, [44:42] net_op, [41:10] net_data,
// [9:0] net_add. net_op: NULL=0, INSTR=1, REG=2, PC=3, BAR=4.
// Optional feature: define LOADER_CHECKSUM_EN to add checksum_o, the running
// 32-bit sum of net_data over every emitted INSTR/REG packet.
module net_packet_loader #(
  parameter logic [9:0]  core_id_p     = 10'b0000000001,
  parameter int unsigned instr_count_p = 1024,
  parameter int unsigned reg_count_p   = 64,
  parameter logic [31:0] start_pc_p    = 32'h5,
  parameter logic [31:0] bar_mask_p    = 32'h2,
  parameter logic [9:0]  bar_add_p     = 10'd24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        hold_i,
  output logic [9:0]  instr_addr_o,
  input  logic [15:0] instr_data_i,
  output logic [5:0]  reg_addr_o,
  input  logic [39:0] reg_data_i,
  output logic [54:0] net_packet_flat_o,
  output logic        busy_o,
  output logic        done_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum_o
`endif
);

  localparam logic [2:0] OP_NULL  = 3'd0;
  localparam logic [2:0] OP_INSTR = 3'd1;
  localparam logic [2:0] OP_REG   = 3'd2;
  localparam logic [2:0] OP_PC    = 3'd3;
  localparam logic [2:0] OP_BAR   = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INSTR = 3'd1;
  localparam logic [2:0] S_REG   = 3'd2;
  localparam logic [2:0] S_PC    = 3'd3;
  localparam logic [2:0] S_BAR   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [9:0]  INSTR_LAST = 10'(instr_count_p - 1);
  localparam logic [9:0]  REG_LAST   = 10'(reg_count_p - 1);
  localparam logic [54:0] NULL_PKT   = {core_id_p, OP_NULL, 32'h0, 10'h0};

  logic [2:0]  state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic        pipe_vld_q, pipe_vld_d;
  logic        pipe_reg_q, pipe_reg_d;
  logic [9:0]  pipe_idx_q, pipe_idx_d;
  logic [54:0] pkt_q, pkt_d;
  logic [31:0] sum_q, sum_d;

  logic [54:0] instr_pkt, reg_pkt, piped_pkt;
  logic        emit_data;
  logic        unused_reg_bits;

  assign unused_reg_bits = ^reg_data_i[39:38];

  // While held, re-present the piped entry's address so the synchronous ROM
  // keeps returning the word that is still waiting to be emitted.
  assign instr_addr_o = (hold_i && pipe_vld_q && !pipe_reg_q) ? pipe_idx_q : idx_q;
  assign reg_addr_o   = (hold_i && pipe_vld_q &&  pipe_reg_q) ? pipe_idx_q[5:0] : idx_q[5:0];

  assign instr_pkt = {core_id_p, OP_INSTR, {16'h0, instr_data_i}, pipe_idx_q};
  assign reg_pkt   = {core_id_p, OP_REG, reg_data_i[31:0], {4'h0, reg_data_i[37:32]}};
  assign piped_pkt = pipe_reg_q ? reg_pkt : instr_pkt;

  // Next-state, address pipe and packet selection
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pipe_vld_d = pipe_vld_q;
    pipe_reg_d = pipe_reg_q;
    pipe_idx_d = pipe_idx_q;
    pkt_d      = NULL_PKT;
    emit_data  = 1'b0;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        state_d = S_INSTR;
        idx_d   = '0;
      end
    end else if (!hold_i) begin
      case (state_q)
        S_INSTR, S_REG: begin
          if (pipe_vld_q) begin
            pkt_d     = piped_pkt;
            emit_data = 1'b1;
          end
          pipe_vld_d = 1'b1;
          pipe_reg_d = (state_q == S_REG);
          pipe_idx_d = idx_q;
          if (state_q == S_INSTR && idx_q == INSTR_LAST) begin
            state_d = S_REG;
            idx_d   = '0;
          end else if (state_q == S_REG && idx_q == REG_LAST) begin
            state_d = S_PC;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
        // The last REG entry drains from the pipe before PC goes out.
        S_PC: begin
          if (pipe_vld_q) begin
            pkt_d      = piped_pkt;
            emit_data  = 1'b1;
            pipe_vld_d = 1'b0;
          end else begin
            pkt_d   = {core_id_p, OP_PC, start_pc_p, 10'h0};
            state_d = S_BAR;
          end
        end
        S_BAR: begin
          pkt_d   = {core_id_p, OP_BAR, bar_mask_p, bar_add_p};
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
    sum_d = emit_data ? sum_q + pkt_d[41:10] : sum_q;
  end

  // State and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_reg_q <= 1'b0;
      pipe_idx_q <= '0;
      pkt_q      <= NULL_PKT;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_reg_q <= pipe_reg_d;
      pipe_idx_q <= pipe_idx_d;
      pkt_q      <= pkt_d;
      sum_q      <= sum_d;
    end
  end

  assign net_packet_flat_o = pkt_q;
  assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o = (state_q == S_DONE);

`ifdef LOADER_CHECKSUM_EN
  assign checksum_o = sum_q;
`else
  logic unused_sum;
  assign unused_sum = ^sum_q;
`endif

endmodule
